// File: rtl/ps2_scan_rx.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver running on the system clock: pin conditioning, frame
// validation, E0/F0 prefix folding into flagged key events, show-ahead event FIFO.
module ps2_scan_rx #(
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES  = 4095,
  parameter int FIFO_DEPTH      = 8,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [ERR_CNT_W-1:0]          err_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // ---- stage p0: synchronisers, debounce, falling-edge strobe
  logic [1:0]     clk_sync_p0, dat_sync_p0;
  logic           filt_clk_p0, filt_prev_p0;
  logic [DBW-1:0] deb_cnt_p0;
  logic           clk_s, dat_s, strobe;

  assign clk_s  = clk_sync_p0[1];
  assign dat_s  = dat_sync_p0[1];
  assign strobe = filt_prev_p0 & ~filt_clk_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_p0  <= 2'b11;
      dat_sync_p0  <= 2'b11;
      filt_clk_p0  <= 1'b1;
      filt_prev_p0 <= 1'b1;
      deb_cnt_p0   <= '0;
    end else begin
      clk_sync_p0  <= {clk_sync_p0[0], ps2clk};
      dat_sync_p0  <= {dat_sync_p0[0], ps2data};
      filt_prev_p0 <= filt_clk_p0;
      if (clk_s != filt_clk_p0) begin
        if (deb_cnt_p0 == DBW'(DEBOUNCE_CYCLES - 1)) begin
          filt_clk_p0 <= clk_s;
          deb_cnt_p0  <= '0;
        end else begin
          deb_cnt_p0 <= deb_cnt_p0 + DBW'(1);
        end
      end else begin
        deb_cnt_p0 <= '0;
      end
    end
  end

  // ---- stage p1: bit assembly, frame check, timeout
  logic [3:0]    bit_cnt;
  logic [9:0]    shift_p0;
  logic [TW-1:0] tmo_cnt;
  logic          last_bit, frame_good, tmo;
  logic [7:0]    rx_byte_p1;
  logic          byte_vld_p1, err_p1;

  // shift_p0[0] is the start bit, [8:1] the data byte, [9] parity; dat_s is the stop bit
  assign last_bit   = strobe && (bit_cnt == 4'd10);
  assign frame_good = ~shift_p0[0] & dat_s & (^shift_p0[9:1]);
  assign tmo        = (bit_cnt != 4'd0) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (strobe) shift_p0 <= {dat_s, shift_p0[9:1]};
    if (last_bit) rx_byte_p1 <= shift_p0[8:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      byte_vld_p1 <= 1'b0;
      err_p1      <= 1'b0;
      err_count   <= '0;
    end else begin
      byte_vld_p1 <= last_bit && frame_good;
      err_p1      <= (last_bit && !frame_good) || tmo;
      if (err_p1) err_count <= sat_inc(err_count);
      if (tmo)         bit_cnt <= '0;
      else if (strobe) bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
      if (strobe || tmo || bit_cnt == 4'd0) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign frame_err = err_p1;

  // ---- stage p2: prefix FSM feeding the FIFO
  state_t     state, state_nx;
  logic       push;
  logic [9:0] push_data;

  always_ff @(posedge clk) begin
    if (rst || err_p1) state <= ST_IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (byte_vld_p1) begin
      if (rx_byte_p1 == 8'hE0)
        state_nx = ST_E0;
      else if (rx_byte_p1 == 8'hF0)
        state_nx = (state == ST_IDLE) ? ST_F0 : (state == ST_E0) ? ST_E0F0 : state;
      else
        state_nx = ST_IDLE;
    end
  end

  always_comb begin
    push      = byte_vld_p1 && (rx_byte_p1 != 8'hE0) && (rx_byte_p1 != 8'hF0);
    push_data = {(state == ST_F0) || (state == ST_E0F0),
                 (state == ST_E0) || (state == ST_E0F0),
                 rx_byte_p1};
  end

  // ---- event FIFO (show-ahead)
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, wr_en;
  logic [9:0]    head;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = (level != '0) && ev_ready;
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    ev_valid   = (level != '0);
    fifo_level = level;
    ev_code    = ev_valid ? head[7:0] : 8'h00;
    ev_ext     = ev_valid & head[8];
    ev_break   = ev_valid & head[9];
  end
endmodule

// File: tb/tb_ps2_scan_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for ps2_scan_rx: PS/2 frames in, key events checked against
// a flag-based prefix model and a queue standing in for the event FIFO.
module tb_ps2_scan_rx;
  localparam int DEB = 4;
  localparam int TMO = 200;
  localparam int FD  = 4;
  localparam int EW  = 8;

  logic          clk = 1'b0;
  logic          rst, ps2clk, ps2data, ev_ready;
  logic          ev_valid, ev_ext, ev_break, overflow, frame_err;
  logic [7:0]    ev_code;
  logic [2:0]    fifo_level;
  logic [EW-1:0] err_count;

  ps2_scan_rx #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(FD),
                .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .fifo_level(fifo_level),
    .overflow(overflow), .frame_err(frame_err), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  int         vectors = 0, miscompares = 0;
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, exp_ovf;
  int         exp_err_cnt, exp_err_total, err_seen;
  int         cyc, stop_fall_cyc, ready_mode;
  bit         lat_chk, prev_valid;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Prefix handling as two sticky flags; the queue is the FIFO content.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1'b1; m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < FD) exp_q.push_back({m_brk, m_ext, b});
      else                   exp_ovf = 1'b1;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    m_ext = 1'b0; m_brk = 1'b0;
    exp_err_total++;
    if (exp_err_cnt < (1 << EW) - 1) exp_err_cnt++;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input bit good);
    for (int i = 0; i < n; i++) begin
      ps2data = bits[i];
      repeat (10) @(posedge clk);
      #1 ps2clk = 1'b0;
      if (i == 10) begin
        stop_fall_cyc = cyc;
        if (good) model_byte(bits[8:1]);
        else      model_err();
      end
      repeat (20) @(posedge clk);
      #1 ps2clk = 1'b1;
      repeat (10) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11, !bad_par);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    chk({name, "_drain"}, exp_q.size(), 0);
    @(negedge clk); @(negedge clk);
    chk({name, "_valid_low"}, ev_valid, 0);
    chk({name, "_level"}, fifo_level, 0);
  endtask

  task automatic check_errs(input string name);
    chk({name, "_err_count"}, err_count, exp_err_cnt);
    chk({name, "_err_pulses"}, err_seen, exp_err_total);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; exp_ovf = 1'b0; exp_err_cnt = 0;
    @(negedge clk);
    chk("rst_valid", ev_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  initial begin
    rst = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; ev_ready = 1'b0;
    cyc = 0; ready_mode = 1; lat_chk = 1'b0; prev_valid = 1'b0;
    exp_err_total = 0; err_seen = 0;
    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(posedge clk); #1;
        ev_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode != 0);
      end
      forever begin
        @(negedge clk);
        if (frame_err) err_seen++;
        // 2 synchroniser stages + debounce window + frame check + FIFO write
        if (lat_chk && ev_valid && !prev_valid) begin
          chk("latency", cyc - stop_fall_cyc, 2 + DEB + 2);
          lat_chk = 1'b0;
        end
        prev_valid = ev_valid;
        if (ev_valid && ev_ready) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_event: got 0x%0h, required none", {ev_break, ev_ext, ev_code});
          end else begin
            chk("event", {ev_break, ev_ext, ev_code}, exp_q.pop_front());
          end
        end
      end
    join_none

    do_reset();

    // plain make code and first-event latency
    lat_chk = 1'b1;
    send_frame(8'h1C, 1'b0);
    wait_drain("t1");
    chk("t1_latency_seen", lat_chk, 0);
    check_errs("t1");

    // extended release
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h74, 1'b0);
    wait_drain("t2");

    // parity error clears prefix state and counts once
    send_frame(8'h1C, 1'b1);
    send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    wait_drain("t3");
    check_errs("t3");

    // mid-frame timeout
    send_bits(11'b000_1010_1010, 5, 1'b1);
    model_err();
    repeat (250) @(posedge clk);
    #1 check_errs("t4");
    send_frame(8'h2A, 1'b0);
    wait_drain("t4");

    // overflow with consumer stalled
    ready_mode = 0;
    send_frame(8'h15, 1'b0); send_frame(8'h1D, 1'b0); send_frame(8'h24, 1'b0);
    send_frame(8'h2D, 1'b0); send_frame(8'h2C, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t5_level", fifo_level, exp_q.size());
    chk("t5_overflow", overflow, exp_ovf);
    ready_mode = 1;
    wait_drain("t5");
    chk("t5_overflow_sticky", overflow, 1);

    // short glitch on an idle bus
    @(posedge clk); #1 ps2clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 ps2clk = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_errs("t6");
    send_frame(8'h1C, 1'b0);
    wait_drain("t6");
    check_errs("t6b");

    // reset in the middle of a frame
    send_frame(8'hE0, 1'b0);
    send_bits(11'b000_0011_0110, 4, 1'b1);
    do_reset();
    repeat (10) @(posedge clk);
    #1 check_errs("t7");
    send_frame(8'h5A, 1'b0);
    wait_drain("t7");

    // randomized traffic with a stuttering consumer
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      int r;
      r = int'($urandom_range(7));
      case (r)
        0:       send_frame(8'hE0, 1'b0);
        1:       send_frame(8'hF0, 1'b0);
        2:       send_frame(8'($urandom), 1'b1);
        default: send_frame(8'($urandom), 1'b0);
      endcase
    end
    wait_drain("rand");
    check_errs("rand");
    chk("rand_overflow", overflow, exp_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
